// File: rtl/peri_spi_host.sv
// peri_spi_host: Wishbone responder driving an SPI device as controller.
// SPI mode 0, MSB first, 8-bit frames, software-controlled chip select.
module peri_spi_host #(
    parameter int          AddrW    = 4,
    parameter int          DataW    = 8,
    parameter int unsigned DivReset = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wb_we_i,
    input  logic [AddrW-1:0] wb_adr_i,
    input  logic [DataW-1:0] wb_dat_i,
    input  logic             wb_stb_i,
    output logic [DataW-1:0] wb_dat_o,
    output logic             wb_ack_o,
    output logic             spi_sck_o,
    output logic             spi_csn_o,
    output logic             spi_sd_o,
    input  logic             spi_sd_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic             r_ack;
    logic [DataW-1:0] r_dat;
    logic [7:0]       r_div;
    logic [7:0]       r_div_lat;
    logic [7:0]       r_cnt;
    logic [7:0]       r_tx;
    logic [7:0]       r_rx_sh;
    logic [7:0]       r_rx_data;
    logic [2:0]       r_bit;
    logic             r_rx_valid;
    logic             r_overrun;
    logic             r_cs_en;

    logic             w_acc;
    logic             w_wr;
    logic             w_rd;
    logic             w_sel_data;
    logic             w_sel_stat;
    logic             w_sel_div;
    logic             w_sel_ctrl;
    logic             w_busy;
    logic             w_tick;
    logic             w_start;
    logic             w_rise;
    logic             w_fall;
    logic             w_done;
    logic [DataW-1:0] w_rdata;

    assign w_acc      = wb_stb_i & ~r_ack;
    assign w_wr       = w_acc & wb_we_i;
    assign w_rd       = w_acc & ~wb_we_i;
    assign w_sel_data = (wb_adr_i == AddrW'(0));
    assign w_sel_stat = (wb_adr_i == AddrW'(1));
    assign w_sel_div  = (wb_adr_i == AddrW'(2));
    assign w_sel_ctrl = (wb_adr_i == AddrW'(3));
    assign w_busy     = (r_state != ST_IDLE);
    assign w_tick     = (r_cnt == r_div_lat);
    assign w_start    = w_wr & w_sel_data & ~w_busy;

    assign wb_ack_o  = r_ack;
    assign wb_dat_o  = r_dat;
    assign spi_sck_o = (r_state == ST_HIGH);
    assign spi_csn_o = ~r_cs_en;
    assign spi_sd_o  = r_tx[7];

    // Read mux: register contents as seen in the access cycle.
    always_comb begin
        w_rdata = '0;
        if (w_sel_data) begin
            w_rdata = DataW'(r_rx_data);
        end else if (w_sel_stat) begin
            w_rdata = DataW'({r_overrun, r_rx_valid, w_busy});
        end else if (w_sel_div) begin
            w_rdata = DataW'(r_div);
        end else if (w_sel_ctrl) begin
            w_rdata = DataW'(r_cs_en);
        end
    end

    // Frame state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus SCK edge strobes; a frame ends on the 8th falling edge.
    always_comb begin
        w_state_nxt = r_state;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_LOW;
                end
            end
            ST_LOW: begin
                if (w_tick) begin
                    w_rise      = 1'b1;
                    w_state_nxt = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (w_tick) begin
                    w_fall = 1'b1;
                    if (r_bit == 3'd7) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_LOW;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Shift datapath: divider, bit counter, tx/rx shift registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_div_lat <= '0;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_tx      <= '0;
            r_rx_sh   <= '0;
        end else if (w_start) begin
            r_div_lat <= r_div;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_tx      <= wb_dat_i[7:0];
        end else if (w_busy) begin
            r_cnt <= w_tick ? 8'd0 : r_cnt + 8'd1;
            if (w_rise) begin
                r_rx_sh <= {r_rx_sh[6:0], spi_sd_i};
            end
            if (w_fall) begin
                r_tx <= {r_tx[6:0], 1'b0};
                if (!w_done) begin
                    r_bit <= r_bit + 3'd1;
                end
            end
        end
    end

    // Bus side: ack, read data and software-visible registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_ack      <= 1'b0;
            r_dat      <= '0;
            r_div      <= 8'(DivReset);
            r_cs_en    <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_ack <= w_acc;
            r_dat <= w_rd ? w_rdata : '0;
            if (w_wr && w_sel_div) begin
                r_div <= wb_dat_i[7:0];
            end
            if (w_wr && w_sel_ctrl) begin
                r_cs_en <= wb_dat_i[0];
            end
            if (w_done) begin
                r_rx_data  <= r_rx_sh;
                r_rx_valid <= 1'b1;
            end else if (w_rd && w_sel_data) begin
                r_rx_valid <= 1'b0;
            end
            if (w_wr && w_sel_data && w_busy) begin
                r_overrun <= 1'b1;
            end else if (w_wr && w_sel_stat && wb_dat_i[2]) begin
                r_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: doc/peri_spi_host.md
Name: peri_spi_host

Overview:
- Wishbone responder peripheral that drives an external SPI device as SPI controller (mode 0, MSB first, 8-bit frames).
- The opposite end of the SPI link from the board's SPI-device Wishbone initiator.
- Sits on the shared peripheral bus beside the LED, debug and charlieplex peripherals, with the same Wishbone signal set.
- Lets software on the bus talk to an attached SPI device (including the FPGA's own SPI-device port in loopback).

Parameters:
AddrW, 4, Wishbone address width
DataW, 8, Wishbone data width; the SPI frame is fixed at 8 bits
DivReset, 1, reset value of the DIV register

Ports:
clk_i  input  1  system clock
rst_ni  input  1  reset, synchronous, active-low
wb_we_i  input  1  write enable
wb_adr_i  input  AddrW  register address
wb_dat_i  input  DataW  write data
wb_stb_i  input  1  strobe, held by the initiator until ack
wb_dat_o  output  DataW  read data, valid while wb_ack_o=1, 0 otherwise
wb_ack_o  output  1  single-cycle acknowledge
spi_sck_o  output  1  SPI clock, idles low
spi_csn_o  output  1  chip select, active-low
spi_sd_o  output  1  controller-to-device data
spi_sd_i  input  1  device-to-controller data

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is synchronous and active-low. Reset takes effect on the next edge, including mid-transfer (the frame is aborted, no rx update).
- Reset values:
  - Outputs: wb_ack_o=0, wb_dat_o=0, spi_sck_o=0, spi_csn_o=1, spi_sd_o=0.
  - Registers: busy=0, rx_valid=0, overrun=0, rx_data=0, DIV=DivReset, CTRL=0.
- Bus handshake:
  - A cycle with wb_stb_i=1 and wb_ack_o=0 is an access; wb_ack_o=1 on the next cycle for exactly one cycle.
  - The access takes effect at that ack edge.
  - Back-to-back access is possible every second cycle.
  - Unmapped addresses still ack: read 0, writes ignored.
- Registers (wb_adr_i):
  - 0 DATA.
    - Write while busy=0 loads tx shift register and starts a frame.
    - Write while busy=1 is ignored and sets overrun.
    - Read returns rx_data and clears rx_valid.
  - 1 STATUS, read only except W1C.
    - bit0 busy, bit1 rx_valid, bit2 overrun, others 0.
    - Writing 1 to bit2 clears overrun.
  - 2 DIV: SCK half-period = DIV+1 clk cycles. Writable any time; the value is latched into the active divider at frame start.
  - 3 CTRL: bit0 cs_en; spi_csn_o = ~cs_en. Software controls framing, so CS may span multiple bytes. Reads back.
- Frame timing, with write acked at edge N:
  - From N+1: busy=1, spi_sck_o=0, spi_sd_o=tx[7].
  - 16 phases of D=DIV_latched+1 cycles each, alternating low/high, starting low.
  - At each low→high SCK transition edge: sample spi_sd_i into rx shift LSB.
  - At each high→low transition: spi_sd_o advances to the next bit.
  - After phase 16 (SCK falls, 8th bit done): busy=0, rx_data=rx shift, rx_valid=1, spi_sd_o=0.
  - busy is high for exactly 16*D cycles.
- State machine: IDLE → LOW (start) → HIGH (D cycles elapsed) → LOW (bit count<7) or IDLE (bit count=7). Divider counter 0..D-1; bit counter 0..7 (3 bits, no wrap beyond 7).
- Simultaneous events:
  - DATA write in the same cycle that busy drops counts as busy: ignored, overrun set.
  - DATA read in the completion cycle returns the old rx_data, and rx_valid ends set (completion wins).
- DIV=255 yields a 256-cycle half-period, with no overflow of the divider counter, which is 8 bits.

Test Plan:
- Reset, then read STATUS/DIV/CTRL → 0x00 / 0x01 / 0x00; spi_csn_o=1, spi_sck_o=0.
- Write CTRL=1, DATA=0xA5 with spi_sd_i looped to spi_sd_o.
  - Expect: 8 SCK pulses each 2 high/2 low cycles, sd_o bits 1,0,1,0,0,1,0,1, busy high 32 cycles.
  - Then STATUS=0x02, DATA read=0xA5, STATUS=0x00.
- DIV=4, DATA=0x3C, spi_sd_i driven by a model shifting out 0xC3 on falling SCK → half-period 5 cycles, busy 80 cycles, rx_data=0xC3.
- Write DATA=0x11 then DATA=0x22 while busy → only 0x11 shifted, STATUS bit2=1; write STATUS=0x04 → bit2 clears.
- Assert rst_ni=0 for one cycle mid-frame (after the 3rd SCK rise) → next cycle outputs and registers are at reset values, rx_valid=0.
- Read adr 7 → ack after 1 cycle, data 0x00; write adr 7=0xFF → no register changes.
